tetris_score_keeper: RTL and testbench

- Game-status stage directly upstream of the UI overlay.
- Converts piece-lock and spawn-collision events from the board logic into:
  - a saturating two-digit `Score`,
  - a speed `Level`,
  - `Win` and `Lose` flags.
- Generates the gravity `Drop_Tick` pulse that paces the falling piece, with the period shortened as `Level` rises.
- The overlay consumes `Score`, `Win` and `Lose` unchanged.

---
 rtl/tetris_score_keeper.sv | 147 ++++++++++++++
 tb/tb_tetris_score_keeper.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_score_keeper.sv
// Game-status stage: score, level, win/lose flags and gravity tick pacing.
// Optional combo bonus is enabled with `define SCORE_COMBO_EN.
module tetris_score_keeper #(
   parameter logic [6:0] WIN_SCORE = 7'd50,
   parameter logic [5:0] DROP_BASE = 6'd30,
   parameter logic [5:0] DROP_STEP = 6'd3,
   parameter logic [5:0] DROP_MIN  = 6'd3
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Restart,
   input  logic       Frame_Pulse,
   input  logic       Lock_Valid,
   input  logic [2:0] Lines_Cleared,
   input  logic       Spawn_Blocked,
   output logic [6:0] Score,
   output logic [3:0] Level,
   output logic       Win,
   output logic       Lose,
   output logic       Drop_Tick
);

   // state | meaning
   // PLAY  | game running: locks score, frames advance gravity
   // WIN   | score reached WIN_SCORE; events ignored until Restart
   // LOSE  | spawn collided with stack; events ignored until Restart
   typedef enum logic [1:0] {PLAY, WIN, LOSE} state_t;

   localparam logic WIN_EN = (WIN_SCORE <= 7'd99);

   state_t     state, state_nxt;
   logic       armed;
   logic [5:0] frame_cnt, cnt_nxt;
   logic [6:0] score_nxt, lock_score, level_q;
   logic [3:0] level_nxt, points;
   logic [7:0] sum;
   logic [9:0] step_prod, period_raw;
   logic [5:0] period;
   logic       tick_nxt, active, do_lock;

   // armed stays low through the first edge after Reset so those events are dropped
   assign active  = (state == PLAY) && armed && !Restart;
   assign do_lock = active && Lock_Valid;

   always_comb begin
      case (Lines_Cleared)
         3'd0:    points = 4'd0;
         3'd1:    points = 4'd1;
         3'd2:    points = 4'd3;
         3'd3:    points = 4'd5;
         default: points = 4'd8;
      endcase
   end

`ifdef SCORE_COMBO_EN
   logic [1:0] combo, combo_nxt, bonus;

   assign bonus = (Lines_Cleared != 3'd0) ? combo : 2'd0;
   assign sum   = {1'b0, Score} + {4'b0, points} + {6'b0, bonus};

   always_comb begin
      combo_nxt = combo;
      if (Restart && armed)
         combo_nxt = 2'd0;
      else if (do_lock) begin
         if (Lines_Cleared == 3'd0)
            combo_nxt = 2'd0;
         else if (combo != 2'd3)
            combo_nxt = combo + 2'd1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         combo <= 2'd0;
      else
         combo <= combo_nxt;
   end
`else
   assign sum = {1'b0, Score} + {4'b0, points};
`endif

   assign lock_score = (sum > 8'd99) ? 7'd99 : sum[6:0];

   // period = max(BASE - level*STEP, MIN), computed wide so it cannot wrap
   assign step_prod  = {6'b0, Level} * {4'b0, DROP_STEP};
   assign period_raw = ({4'b0, DROP_BASE} > step_prod) ? ({4'b0, DROP_BASE} - step_prod) : 10'd0;
   assign period     = (period_raw < {4'b0, DROP_MIN}) ? DROP_MIN : period_raw[5:0];

   always_comb begin
      state_nxt = state;
      score_nxt = Score;
      cnt_nxt   = frame_cnt;
      tick_nxt  = 1'b0;
      if (Restart && armed) begin
         state_nxt = PLAY;
         score_nxt = 7'd0;
         cnt_nxt   = 6'd0;
      end else if (active) begin
         if (Lock_Valid)
            score_nxt = lock_score;
         if (WIN_EN && (score_nxt >= WIN_SCORE))
            state_nxt = WIN;
         else if (Spawn_Blocked)
            state_nxt = LOSE;
         if (Frame_Pulse) begin
            if (({1'b0, frame_cnt} + 7'd1) >= {1'b0, period}) begin
               cnt_nxt  = 6'd0;
               tick_nxt = 1'b1;
            end else begin
               cnt_nxt = frame_cnt + 6'd1;
            end
         end
      end
   end

   assign level_q   = score_nxt / 7'd10;
   assign level_nxt = (level_q > 7'd9) ? 4'd9 : level_q[3:0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         state <= PLAY;
      else
         state <= state_nxt;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         armed     <= 1'b0;
         Score     <= 7'd0;
         Level     <= 4'd0;
         Win       <= 1'b0;
         Lose      <= 1'b0;
         Drop_Tick <= 1'b0;
         frame_cnt <= 6'd0;
      end else begin
         armed     <= 1'b1;
         Score     <= score_nxt;
         Level     <= level_nxt;
         Win       <= (state_nxt == WIN);
         Lose      <= (state_nxt == LOSE);
         Drop_Tick <= tick_nxt;
         frame_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_tetris_score_keeper.sv
// Directed bench for tetris_score_keeper; three instances share stimulus
// (WIN_SCORE 50, 10 and 100) and each phase checks the instance it targets.
module tb_tetris_score_keeper;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       restart = 1'b0;
   logic       fp = 1'b0;
   logic       lv = 1'b0;
   logic [2:0] lines = 3'd0;
   logic       sb = 1'b0;

   logic [6:0] a_score, b_score, c_score;
   logic [3:0] a_level, b_level, c_level;
   logic       a_win, b_win, c_win;
   logic       a_lose, b_lose, c_lose;
   logic       a_tick, b_tick, c_tick;

   int n_checks = 0;
   int n_fail   = 0;
   int ticks;

   tetris_score_keeper #(.WIN_SCORE(7'd50)) dut_a (
      .Clk(clk), .Reset(rst), .Restart(restart), .Frame_Pulse(fp), .Lock_Valid(lv),
      .Lines_Cleared(lines), .Spawn_Blocked(sb), .Score(a_score), .Level(a_level),
      .Win(a_win), .Lose(a_lose), .Drop_Tick(a_tick));

   tetris_score_keeper #(.WIN_SCORE(7'd10)) dut_b (
      .Clk(clk), .Reset(rst), .Restart(restart), .Frame_Pulse(fp), .Lock_Valid(lv),
      .Lines_Cleared(lines), .Spawn_Blocked(sb), .Score(b_score), .Level(b_level),
      .Win(b_win), .Lose(b_lose), .Drop_Tick(b_tick));

   tetris_score_keeper #(.WIN_SCORE(7'd100)) dut_c (
      .Clk(clk), .Reset(rst), .Restart(restart), .Frame_Pulse(fp), .Lock_Valid(lv),
      .Lines_Cleared(lines), .Spawn_Blocked(sb), .Score(c_score), .Level(c_level),
      .Win(c_win), .Lose(c_lose), .Drop_Tick(c_tick));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_lock(input logic [2:0] l, input logic blocked = 1'b0);
      @(negedge clk);
      lv = 1'b1; lines = l; sb = blocked;
      @(negedge clk);
      lv = 1'b0; lines = 3'd0; sb = 1'b0;
   endtask

   task automatic do_spawn();
      @(negedge clk);
      sb = 1'b1;
      @(negedge clk);
      sb = 1'b0;
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic do_frame();
      @(negedge clk);
      fp = 1'b1;
      @(negedge clk);
      fp = 1'b0;
   endtask

   initial begin
      // reset asserts asynchronously with no clock edge needed
      #1 rst = 1'b1;
      #1;
      check_eq("rst_score", a_score, 0);
      check_eq("rst_level", a_level, 0);
      check_eq("rst_win",   a_win,   0);
      check_eq("rst_lose",  a_lose,  0);
      check_eq("rst_tick",  a_tick,  0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // four-line clears, zero-line clear breaks combo, 7 treated as 4
      do_lock(3'd4);
      check_eq("lock4_score", a_score, 8);
      check_eq("lock4_level", a_level, 0);
      do_lock(3'd4);
`ifdef SCORE_COMBO_EN
      check_eq("lock4x2_score", a_score, 17);
      do_lock(3'd0);
      check_eq("lock0_score", a_score, 17);
      do_lock(3'd1);
      check_eq("lock1_score", a_score, 18);
      do_lock(3'd7);
      check_eq("lock7_score", a_score, 27);
`else
      check_eq("lock4x2_score", a_score, 16);
      do_lock(3'd0);
      check_eq("lock0_score", a_score, 16);
      do_lock(3'd1);
      check_eq("lock1_score", a_score, 17);
      do_lock(3'd7);
      check_eq("lock7_score", a_score, 25);
`endif
      check_eq("lock7_level", a_level, 2);

      // drop tick at level 0: only the 30th of 59 pulses ticks
      do_restart();
      check_eq("restart_score", a_score, 0);
      check_eq("restart_level", a_level, 0);
      ticks = 0;
      for (int i = 1; i <= 59; i++) begin
         do_frame();
         check_eq($sformatf("l0_tick_%0d", i), a_tick, (i == 30) ? 1 : 0);
         if (a_tick) ticks++;
         @(negedge clk);
         check_eq($sformatf("l0_tick_off_%0d", i), a_tick, 0);
      end
      check_eq("l0_tick_count", ticks, 1);

      // win beats simultaneous spawn collision (WIN_SCORE=10)
      do_restart();
      do_lock(3'd4);
      check_eq("w10_pre_score", b_score, 8);
      check_eq("w10_pre_win", b_win, 0);
      do_lock(3'd2, 1'b1);
`ifdef SCORE_COMBO_EN
      check_eq("w10_score", b_score, 12);
`else
      check_eq("w10_score", b_score, 11);
`endif
      check_eq("w10_level", b_level, 1);
      check_eq("w10_win", b_win, 1);
      check_eq("w10_lose", b_lose, 0);
      do_lock(3'd4);
      do_spawn();
`ifdef SCORE_COMBO_EN
      check_eq("w10_hold_score", b_score, 12);
`else
      check_eq("w10_hold_score", b_score, 11);
`endif
      check_eq("w10_hold_lose", b_lose, 0);
      do_restart();
      check_eq("w10_restart_win", b_win, 0);
      check_eq("w10_restart_score", b_score, 0);

      // lose, frames ignored, restart
      do_lock(3'd3);
      check_eq("lose_pre_score", a_score, 5);
      do_spawn();
      check_eq("lose_flag", a_lose, 1);
      check_eq("lose_win", a_win, 0);
      ticks = 0;
      for (int i = 0; i < 35; i++) begin
         do_frame();
         if (a_tick) ticks++;
      end
      check_eq("lose_tick_count", ticks, 0);
      do_lock(3'd4);
      check_eq("lose_hold_score", a_score, 5);
      do_restart();
      check_eq("lose_restart_flag", a_lose, 0);
      check_eq("lose_restart_score", a_score, 0);

      // saturation and minimum period (WIN_SCORE=100 disables winning)
      do_restart();
      for (int i = 0; i < 6; i++) do_lock(3'd4);
`ifdef SCORE_COMBO_EN
      check_eq("sat_mid_score", c_score, 60);
      check_eq("sat_mid_level", c_level, 6);
`else
      check_eq("sat_mid_score", c_score, 48);
      check_eq("sat_mid_level", c_level, 4);
`endif
      for (int i = 0; i < 7; i++) do_lock(3'd4);
      check_eq("sat_score", c_score, 99);
      check_eq("sat_level", c_level, 9);
      check_eq("sat_win", c_win, 0);
      for (int i = 1; i <= 9; i++) begin
         do_frame();
         check_eq($sformatf("l9_tick_%0d", i), c_tick, ((i % 3) == 0) ? 1 : 0);
      end

      // async reset mid-game
      do_restart();
      for (int i = 0; i < 5; i++) do_lock(3'd4);
`ifdef SCORE_COMBO_EN
      check_eq("areset_pre_score", a_score, 49);
`else
      check_eq("areset_pre_score", a_score, 40);
`endif
      check_eq("areset_pre_level", a_level, 4);
      check_eq("areset_pre_bwin", b_win, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("areset_score", a_score, 0);
      check_eq("areset_level", a_level, 0);
      check_eq("areset_bwin", b_win, 0);
      check_eq("areset_lose", a_lose, 0);
      check_eq("areset_tick", a_tick, 0);

      // lock present in the deassertion cycle is dropped
      @(negedge clk);
      rst = 1'b0; lv = 1'b1; lines = 3'd4;
      @(negedge clk);
      lv = 1'b0; lines = 3'd0;
      check_eq("deassert_ignored", a_score, 0);
      do_lock(3'd4);
      check_eq("post_reset_lock", a_score, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
